// File: rtl/md5_stream.sv
// Streaming MD5 engine: accepts a byte message as little-endian 32-bit words,
// appends RFC 1321 padding and the 64-bit bit length, hashes each 512-bit block
// with UNROLL chained steps per clock, and emits the byte-ordered digest.
//
// Handshake: a word transfers on a rising clk edge where s_valid and s_ready
// are both high. s_ready depends only on the FSM state and abort, never on
// s_valid. The producer must hold s_data/s_last/s_keep stable while s_valid
// is high and s_ready is low.
module md5_stream #(
    parameter int UNROLL = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         abort,
    input  logic         s_valid,
    output logic         s_ready,
    input  logic [31:0]  s_data,
    input  logic         s_last,
    input  logic [2:0]   s_keep,
    output logic         busy,
    output logic         digest_valid,
    output logic [127:0] digest,
    output logic [2:0]   fsm_state
);

    generate
        if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 4)) begin : g_bad_unroll
            $error("md5_stream: UNROLL must be 1, 2 or 4");
        end
    endgenerate

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        PAD  = 3'd2,
        HASH = 3'd3,
        ADD  = 3'd4
    } state_t;

    localparam logic [31:0] IV_A = 32'h67452301;
    localparam logic [31:0] IV_B = 32'hefcdab89;
    localparam logic [31:0] IV_C = 32'h98badcfe;
    localparam logic [31:0] IV_D = 32'h10325476;

    localparam logic [31:0] K_TAB [64] = '{
        32'hd76aa478, 32'he8c7b756, 32'h242070db, 32'hc1bdceee,
        32'hf57c0faf, 32'h4787c62a, 32'ha8304613, 32'hfd469501,
        32'h698098d8, 32'h8b44f7af, 32'hffff5bb1, 32'h895cd7be,
        32'h6b901122, 32'hfd987193, 32'ha679438e, 32'h49b40821,
        32'hf61e2562, 32'hc040b340, 32'h265e5a51, 32'he9b6c7aa,
        32'hd62f105d, 32'h02441453, 32'hd8a1e681, 32'he7d3fbc8,
        32'h21e1cde6, 32'hc33707d6, 32'hf4d50d87, 32'h455a14ed,
        32'ha9e3e905, 32'hfcefa3f8, 32'h676f02d9, 32'h8d2a4c8a,
        32'hfffa3942, 32'h8771f681, 32'h6d9d6122, 32'hfde5380c,
        32'ha4beea44, 32'h4bdecfa9, 32'hf6bb4b60, 32'hbebfbc70,
        32'h289b7ec6, 32'heaa127fa, 32'hd4ef3085, 32'h04881d05,
        32'hd9d4d039, 32'he6db99e5, 32'h1fa27cf8, 32'hc4ac5665,
        32'hf4292244, 32'h432aff97, 32'hab9423a7, 32'hfc93a039,
        32'h655b59c3, 32'h8f0ccc92, 32'hffeff47d, 32'h85845dd1,
        32'h6fa87e4f, 32'hfe2ce6e0, 32'ha3014314, 32'h4e0811a1,
        32'hf7537e82, 32'hbd3af235, 32'h2ad7d2bb, 32'heb86d391
    };

    // Rotation amounts indexed by {round, step mod 4}.
    localparam logic [4:0] S_TAB [16] = '{
        5'd7, 5'd12, 5'd17, 5'd22,
        5'd5, 5'd9,  5'd14, 5'd20,
        5'd4, 5'd11, 5'd16, 5'd23,
        5'd6, 5'd10, 5'd15, 5'd21
    };

    function automatic logic [31:0] rotl(input logic [31:0] x, input logic [4:0] s);
        return (x << s) | (x >> (6'd32 - {1'b0, s}));
    endfunction

    function automatic logic [31:0] bswap(input logic [31:0] x);
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
    endfunction

    state_t       state, state_next;
    logic [31:0]  mem [16];
    logic [3:0]   widx;
    logic [60:0]  count;
    logic [5:0]   step;
    logic         need80;      // 0x80 terminator still has to be written by PAD
    logic         tail;        // last word received, message is being closed
    logic         len_in_blk;  // the block being built carries the length words
    logic [31:0]  ca, cb, cc, cd;
    logic [31:0]  wa, wb, wc, wd;
    logic [31:0]  na, nb, nc, nd;
    logic [31:0]  sa, sb, sc, sd;
    logic         accept;
    logic [2:0]   keep_eff;
    logic [31:0]  last_word;
    logic [31:0]  pad_word;
    logic         mem_we;
    logic [31:0]  mem_wdata;

    assign s_ready   = (state == LOAD) & ~abort;
    assign accept    = s_valid & s_ready;
    assign keep_eff  = (s_keep > 3'd4) ? 3'd4 : s_keep;
    assign fsm_state = state;

    assign sa = ca + wa;
    assign sb = cb + wb;
    assign sc = cc + wc;
    assign sd = cd + wd;

    // Final word: keep valid bytes, drop the 0x80 terminator right after them.
    always_comb begin
        last_word = '0;
        for (int b = 0; b < 4; b++) begin
            if (3'(b) < keep_eff)
                last_word[8*b +: 8] = s_data[8*b +: 8];
            else if (3'(b) == keep_eff)
                last_word[8*b +: 8] = 8'h80;
        end
    end

    // Padding word for the current PAD slot: terminator, length, or zero.
    always_comb begin
        pad_word = '0;
        if (need80)
            pad_word = 32'h0000_0080;
        else if (len_in_blk && widx == 4'd14)
            pad_word = {count[28:0], 3'b000};
        else if (len_in_blk && widx == 4'd15)
            pad_word = count[60:29];
    end

    // Buffer write port: accepted words in LOAD, padding words in PAD.
    always_comb begin
        mem_we    = 1'b0;
        mem_wdata = '0;
        if (accept) begin
            mem_we    = 1'b1;
            mem_wdata = s_last ? last_word : s_data;
        end else if (state == PAD) begin
            mem_we    = 1'b1;
            mem_wdata = pad_word;
        end
    end

    // Message block storage.
    always_ff @(posedge clk) begin
        if (mem_we)
            mem[widx] <= mem_wdata;
    end

    // UNROLL chained MD5 steps starting at step index 'step'.
    always_comb begin
        logic [31:0] ta, tb, tc, td, f, t;
        logic [5:0]  i;
        logic [3:0]  g;
        ta = wa;
        tb = wb;
        tc = wc;
        td = wd;
        f  = '0;
        t  = '0;
        i  = '0;
        g  = '0;
        for (int j = 0; j < UNROLL; j++) begin
            i = step + 6'(j);
            case (i[5:4])
                2'd0: begin
                    f = (tb & tc) | (~tb & td);
                    g = i[3:0];
                end
                2'd1: begin
                    f = (tb & td) | (tc & ~td);
                    g = 4'(i * 6'd5 + 6'd1);
                end
                2'd2: begin
                    f = tb ^ tc ^ td;
                    g = 4'(i * 6'd3 + 6'd5);
                end
                default: begin
                    f = tc ^ (tb | ~td);
                    g = 4'(i * 6'd7);
                end
            endcase
            t  = rotl(ta + f + K_TAB[i] + mem[g], S_TAB[{i[5:4], i[1:0]}]);
            ta = td;
            td = tc;
            tc = tb;
            tb = tb + t;
        end
        na = ta;
        nb = tb;
        nc = tc;
        nd = td;
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    // FSM next-state logic; abort wins over every transition.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: state_next = LOAD;
            LOAD: begin
                if (accept) begin
                    if (widx == 4'd15)
                        state_next = HASH;
                    else if (s_last)
                        state_next = PAD;
                end
            end
            PAD:  if (widx == 4'd15) state_next = HASH;
            HASH: if (step == 6'(64 - UNROLL)) state_next = ADD;
            ADD:  state_next = (tail && !len_in_blk) ? PAD : LOAD;
            default: state_next = IDLE;
        endcase
        if (abort)
            state_next = IDLE;
    end

    // Working registers: seeded from the chain on HASH entry, then stepped.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wa <= '0;
            wb <= '0;
            wc <= '0;
            wd <= '0;
        end else if (state != HASH && state_next == HASH) begin
            wa <= ca;
            wb <= cb;
            wc <= cc;
            wd <= cd;
        end else if (state == HASH) begin
            wa <= na;
            wb <= nb;
            wc <= nc;
            wd <= nd;
        end
    end

    // Message bookkeeping, chaining values and digest output.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            widx         <= '0;
            count        <= '0;
            step         <= '0;
            need80       <= 1'b0;
            tail         <= 1'b0;
            len_in_blk   <= 1'b0;
            busy         <= 1'b0;
            digest_valid <= 1'b0;
            digest       <= '0;
            ca           <= IV_A;
            cb           <= IV_B;
            cc           <= IV_C;
            cd           <= IV_D;
        end else if (abort) begin
            widx         <= '0;
            count        <= '0;
            step         <= '0;
            need80       <= 1'b0;
            tail         <= 1'b0;
            len_in_blk   <= 1'b0;
            busy         <= 1'b0;
            digest_valid <= 1'b0;
            ca           <= IV_A;
            cb           <= IV_B;
            cc           <= IV_C;
            cd           <= IV_D;
        end else begin
            digest_valid <= 1'b0;
            case (state)
                LOAD: begin
                    if (accept) begin
                        busy <= 1'b1;
                        widx <= widx + 4'd1;
                        if (s_last) begin
                            count      <= count + 61'(keep_eff);
                            need80     <= (keep_eff == 3'd4);
                            tail       <= 1'b1;
                            // Length fits only if the terminator lands at word 13 or below.
                            len_in_blk <= (widx <= 4'd12) ||
                                          (widx == 4'd13 && keep_eff != 3'd4);
                        end else begin
                            count <= count + 61'd4;
                        end
                    end
                end
                PAD: begin
                    widx   <= widx + 4'd1;
                    need80 <= 1'b0;
                end
                HASH: begin
                    step <= step + 6'(UNROLL);
                end
                ADD: begin
                    step <= '0;
                    widx <= '0;
                    if (tail && len_in_blk) begin
                        digest       <= {bswap(sa), bswap(sb), bswap(sc), bswap(sd)};
                        digest_valid <= 1'b1;
                        busy         <= 1'b0;
                        count        <= '0;
                        tail         <= 1'b0;
                        len_in_blk   <= 1'b0;
                        ca           <= IV_A;
                        cb           <= IV_B;
                        cc           <= IV_C;
                        cd           <= IV_D;
                    end else begin
                        // Second padding block (if tail) always carries the length.
                        len_in_blk <= tail;
                        ca         <= sa;
                        cb         <= sb;
                        cc         <= sc;
                        cd         <= sd;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_md5_stream.sv
// Directed bench for md5_stream: three instances (UNROLL 1, 2, 4) share the
// data, abort and reset lines; each has its own s_valid.
module tb_md5_stream;

    localparam logic [127:0] D_EMPTY = 128'hd41d8cd98f00b204e9800998ecf8427e;
    localparam logic [127:0] D_ABC   = 128'h900150983cd24fb0d6963f7d28e17f72;
    localparam logic [127:0] D_A     = 128'h0cc175b9c0f1b6a831c399e269772661;
    localparam logic [127:0] D_56    = 128'h8215ef0796a20bcaaae116d3876c664a;

    logic         clk = 1'b0;
    logic         reset;
    logic         abort;
    logic [31:0]  s_data;
    logic         s_last;
    logic [2:0]   s_keep;
    logic         s_valid      [3];
    logic         s_ready      [3];
    logic         busy         [3];
    logic         digest_valid [3];
    logic [127:0] digest       [3];
    logic [2:0]   fsm_state    [3];

    int n_cmp  = 0;
    int n_fail = 0;
    int dv_cnt [3];

    logic [31:0] w56 [14] = '{
        32'h64636261, 32'h65646362, 32'h66656463, 32'h67666564,
        32'h68676665, 32'h69686766, 32'h6a696867, 32'h6b6a6968,
        32'h6c6b6a69, 32'h6d6c6b6a, 32'h6e6d6c6b, 32'h6f6e6d6c,
        32'h706f6e6d, 32'h71706f6e
    };

    always #5 clk = ~clk;

    for (genvar k = 0; k < 3; k++) begin : g_dut
        md5_stream #(.UNROLL(1 << k)) dut (
            .clk          (clk),
            .reset        (reset),
            .abort        (abort),
            .s_valid      (s_valid[k]),
            .s_ready      (s_ready[k]),
            .s_data       (s_data),
            .s_last       (s_last),
            .s_keep       (s_keep),
            .busy         (busy[k]),
            .digest_valid (digest_valid[k]),
            .digest       (digest[k]),
            .fsm_state    (fsm_state[k])
        );
    end

    initial begin
        for (int k = 0; k < 3; k++) dv_cnt[k] = 0;
    end

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++)
            if (digest_valid[k] === 1'b1) dv_cnt[k] = dv_cnt[k] + 1;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Offer one word to instance u and hold it until the handshake edge.
    task automatic send_word(input int u, input logic [31:0] d, input logic l,
                             input logic [2:0] k);
        int guard;
        guard    = 0;
        s_data   = d;
        s_last   = l;
        s_keep   = k;
        s_valid[u] = 1'b1;
        @(negedge clk);
        while (s_ready[u] !== 1'b1 && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        chk("ready_wait", 128'(s_ready[u]), 128'(1'b1));
        @(posedge clk);
        #1;
        s_valid[u] = 1'b0;
    endtask

    // Called #1 after the accepting edge of the last word.
    task automatic wait_digest(input int u, input int lat, input logic [127:0] exp,
                               input string tag);
        int edges;
        edges = 0;
        chk({tag, "_busy_start"}, 128'(busy[u]), 128'(1'b1));
        while (digest_valid[u] !== 1'b1 && edges < 400) begin
            @(posedge clk);
            #1;
            edges++;
        end
        chk({tag, "_latency"}, 128'(edges), 128'(lat));
        chk({tag, "_digest"}, digest[u], exp);
        chk({tag, "_busy_end"}, 128'(busy[u]), 128'(1'b0));
    endtask

    initial begin
        int cnt0;
        reset  = 1'b1;
        abort  = 1'b0;
        s_data = '0;
        s_last = 1'b0;
        s_keep = '0;
        for (int k = 0; k < 3; k++) s_valid[k] = 1'b0;
        #2 reset = 1'b0;
        #2;
        for (int k = 0; k < 3; k++) begin
            chk("rst_ready",  128'(s_ready[k]),      128'(1'b0));
            chk("rst_busy",   128'(busy[k]),         128'(1'b0));
            chk("rst_dvalid", 128'(digest_valid[k]), 128'(1'b0));
            chk("rst_digest", digest[k],             128'h0);
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        chk("ready_at_release", 128'(s_ready[0]), 128'(1'b0));
        @(posedge clk);
        #1;
        chk("ready_after_release", 128'(s_ready[0]), 128'(1'b1));

        // Empty message.
        send_word(0, 32'h0, 1'b1, 3'd0);
        wait_digest(0, 80, D_EMPTY, "empty");

        // Full block of a message that never finishes, aborted mid-HASH.
        for (int w = 0; w < 16; w++) send_word(0, $urandom, 1'b0, 3'd4);
        chk("abort_ready_in_hash", 128'(s_ready[0]), 128'(1'b0));
        cnt0 = dv_cnt[0];
        repeat (10) @(posedge clk);
        #1;
        chk("abort_busy_before", 128'(busy[0]), 128'(1'b1));
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        chk("abort_ready_idle", 128'(s_ready[0]),      128'(1'b0));
        chk("abort_busy",       128'(busy[0]),         128'(1'b0));
        chk("abort_dvalid",     128'(digest_valid[0]), 128'(1'b0));
        chk("abort_digest_held", digest[0], D_EMPTY);
        @(posedge clk);
        #1;
        chk("abort_ready_load", 128'(s_ready[0]), 128'(1'b1));
        repeat (80) @(posedge clk);
        #1;
        chk("abort_no_pulse", 128'(dv_cnt[0]), 128'(cnt0));
        chk("abort_digest_still_held", digest[0], D_EMPTY);

        // "abc" on each unroll factor.
        send_word(0, 32'h00636261, 1'b1, 3'd3);
        wait_digest(0, 80, D_ABC, "abc_u1");
        send_word(1, 32'h00636261, 1'b1, 3'd3);
        wait_digest(1, 48, D_ABC, "abc_u2");
        send_word(2, 32'h00636261, 1'b1, 3'd3);
        wait_digest(2, 32, D_ABC, "abc_u4");

        // 56-byte message: terminator lands in word 14, two-block finish.
        for (int w = 0; w < 13; w++) send_word(0, w56[w], 1'b0, 3'd4);
        send_word(0, w56[13], 1'b1, 3'd4);
        chk("m56_ready_pad", 128'(s_ready[0]), 128'(1'b0));
        wait_digest(0, 148, D_56, "m56");

        // "a" after a random gap, then "abc" offered in the digest_valid cycle.
        repeat ($urandom_range(1, 4)) @(posedge clk);
        #1;
        send_word(0, 32'h00000061, 1'b1, 3'd1);
        wait_digest(0, 80, D_A, "a");
        send_word(0, 32'h00636261, 1'b1, 3'd3);
        chk("b2b_dvalid_drop", 128'(digest_valid[0]), 128'(1'b0));
        chk("b2b_digest_held", digest[0], D_A);
        wait_digest(0, 80, D_ABC, "b2b_abc");

        // Reset in the middle of HASH.
        send_word(0, 32'h00636261, 1'b1, 3'd3);
        repeat (20) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("midrst_ready",  128'(s_ready[0]),      128'(1'b0));
        chk("midrst_busy",   128'(busy[0]),         128'(1'b0));
        chk("midrst_dvalid", 128'(digest_valid[0]), 128'(1'b0));
        chk("midrst_digest", digest[0],             128'h0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("midrst_ready_release", 128'(s_ready[0]), 128'(1'b0));
        @(posedge clk);
        #1;
        chk("midrst_ready_edge", 128'(s_ready[0]), 128'(1'b1));
        send_word(0, 32'h00636261, 1'b1, 3'd3);
        wait_digest(0, 80, D_ABC, "post_rst_abc");
        @(posedge clk);
        #1;
        chk("final_dvalid_low", 128'(digest_valid[0]), 128'(1'b0));
        chk("final_digest_held", digest[0], D_ABC);

        chk("pulses_u1", 128'(dv_cnt[0]), 128'(6));
        chk("pulses_u2", 128'(dv_cnt[1]), 128'(1));
        chk("pulses_u4", 128'(dv_cnt[2]), 128'(1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
